// File: rtl/comparator_serial_cmp.sv
// comparator_serial_cmp
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared
// DIGIT bits per cycle, most-significant digit first. Operands are unsigned
// or two's complement (SIGNED), and the operation can stop on the first
// differing digit (EARLY_EXIT=1) or always spend WIDTH/DIGIT compare cycles
// (EARLY_EXIT=0, constant latency).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair offered
//   in_ready   block can accept (high only while idle)
//   a, b       operands, captured on in_valid & in_ready
//   out_valid  result available (high only while holding a result)
//   out_ready  consumer accepts the result
//   eq/gt/lt   registered result, one-hot whenever out_valid is high;
//              held until the next result is produced

module comparator_serial_cmp #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int SIGNED     = 0,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((WIDTH <= 0) || (DIGIT <= 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
      $error("comparator_serial_cmp: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx;
  logic             sticky_diff;
  logic             sticky_gt;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_ne, dig_gt;
  logic             last_dig;
  logic             accept;

  logic load_res;
  logic eq_nxt, gt_nxt, lt_nxt;

  // Unsigned digit compare; returns {differ, a_greater}.
  function automatic logic [1:0] digit_cmp(input logic [DIGIT-1:0] x,
                                           input logic [DIGIT-1:0] y);
    digit_cmp = {(x != y), (x > y)};
  endfunction

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && (state == S_IDLE);

  assign dig_a             = a_q[int'(idx) * DIGIT +: DIGIT];
  assign dig_b             = b_q[int'(idx) * DIGIT +: DIGIT];
  assign {dig_ne, dig_gt}  = digit_cmp(dig_a, dig_b);
  assign last_dig          = (idx == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and result load
  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    eq_nxt    = 1'b0;
    gt_nxt    = 1'b0;
    lt_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (EARLY_EXIT != 0) begin
          if (dig_ne) begin
            load_res  = 1'b1;
            gt_nxt    = dig_gt;
            lt_nxt    = !dig_gt;
            state_nxt = S_DONE;
          end else if (last_dig) begin
            load_res  = 1'b1;
            eq_nxt    = 1'b1;
            state_nxt = S_DONE;
          end
        end else if (last_dig) begin
          // The sticky value covers digits above this one; if nothing has
          // differed yet, the lowest digit decides.
          load_res  = 1'b1;
          state_nxt = S_DONE;
          if (sticky_diff) begin
            gt_nxt = sticky_gt;
            lt_nxt = !sticky_gt;
          end else if (dig_ne) begin
            gt_nxt = dig_gt;
            lt_nxt = !dig_gt;
          end else begin
            eq_nxt = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Digit index: starts at the top digit, walks down one per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (accept) begin
      idx <= IDX_W'(NDIG - 1);
    end else if ((state == S_RUN) && !last_dig) begin
      idx <= idx - 1'b1;
    end
  end

  // Result registers, written only when a result is produced
  always_ff @(posedge clk) begin
    if (rst) begin
      eq <= 1'b0;
      gt <= 1'b0;
      lt <= 1'b0;
    end else if (load_res) begin
      eq <= eq_nxt;
      gt <= gt_nxt;
      lt <= lt_nxt;
    end
  end

  // Operand capture. Flipping the sign bit of both operands maps two's
  // complement order onto unsigned order, so the digit walk stays unsigned.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
      if (SIGNED != 0) begin
        a_q[WIDTH-1] <= ~a[WIDTH-1];
        b_q[WIDTH-1] <= ~b[WIDTH-1];
      end
    end
  end

  // First-difference latch for the constant-latency mode
  always_ff @(posedge clk) begin
    if (accept) begin
      sticky_diff <= 1'b0;
      sticky_gt   <= 1'b0;
    end else if ((state == S_RUN) && !sticky_diff && dig_ne) begin
      sticky_diff <= 1'b1;
      sticky_gt   <= dig_gt;
    end
  end

endmodule

// File: tb/tb_comparator_serial_cmp.sv
// Bench for comparator_serial_cmp: several configurations run side by side on
// one clock, each with a directed phase, a held-result/stall phase, a reset
// phase and a randomized phase, all checked every cycle against a
// latency/result model derived from integer compares.

module tb_comparator_serial_cmp;

  localparam int NCFG  = 5;
  localparam int NVEC  = 10;
  localparam int NRAND = 12000;

  logic clk;
  int   checks;
  int   failures;
  int   done_cnt;

  // Configuration table: WIDTH, DIGIT, SIGNED, EARLY_EXIT
  function automatic int cfg_w(int g);
    case (g)
      3:       return 12;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_d(int g);
    case (g)
      2:       return 16;
      3:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_s(int g);
    case (g)
      2, 3, 4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_e(int g);
    case (g)
      1, 2:    return 0;
      default: return 1;
    endcase
  endfunction

  // Hand-computed vectors: {cfg, a, b, {eq,gt,lt}, edges from accept to result}
  typedef struct packed {
    logic [3:0]  cfg;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  bits;
    logic [3:0]  lat;
  } vec_t;

  function automatic vec_t get_vec(int i);
    vec_t v;
    case (i)
      0:       v = {4'd0, 16'h8000, 16'h7FFF, 3'b010, 4'd1};
      1:       v = {4'd0, 16'h1234, 16'h1235, 3'b001, 4'd4};
      2:       v = {4'd0, 16'hA5A5, 16'hA5A5, 3'b100, 4'd4};
      3:       v = {4'd1, 16'h8000, 16'h7FFF, 3'b010, 4'd4};
      4:       v = {4'd2, 16'hFFFF, 16'h0001, 3'b001, 4'd1};
      5:       v = {4'd2, 16'h8000, 16'h7FFF, 3'b001, 4'd1};
      6:       v = {4'd4, 16'hFFFF, 16'h0001, 3'b001, 4'd1};
      7:       v = {4'd4, 16'h8000, 16'h8001, 3'b001, 4'd4};
      8:       v = {4'd3, 16'h0800, 16'h07FF, 3'b001, 4'd1};
      default: v = {4'd3, 16'h0123, 16'h0120, 3'b010, 4'd4};
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W    = cfg_w(g);
    localparam int D    = cfg_d(g);
    localparam int S    = cfg_s(g);
    localparam int E    = cfg_e(g);
    localparam int NDIG = W / D;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic         eq;
    logic         gt;
    logic         lt;
    logic         chk_en = 1'b0;

    comparator_serial_cmp #(
      .WIDTH      (W),
      .DIGIT      (D),
      .SIGNED     (S),
      .EARLY_EXIT (E)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .eq        (eq),
      .gt        (gt),
      .lt        (lt)
    );

    // Reference result {eq,gt,lt} from integer values of the operands
    function automatic logic [2:0] ref_bits(input logic [W-1:0] x, input logic [W-1:0] y);
      longint xv, yv;
      xv = longint'(x);
      yv = longint'(y);
      if (S != 0) begin
        if (x[W-1]) xv = xv - (longint'(1) << W);
        if (y[W-1]) yv = yv - (longint'(1) << W);
      end
      if (xv == yv) return 3'b100;
      if (xv > yv)  return 3'b010;
      return 3'b001;
    endfunction

    // Edges from the accept edge until out_valid is high. The sign-bit flip
    // affects both operands alike, so the first differing digit is that of x^y.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] diff;
      int p;
      diff = x ^ y;
      if ((E == 0) || (diff == '0)) return NDIG;
      p = W - 1;
      while (!diff[p]) p--;
      return NDIG - (p / D);
    endfunction

    // Model state: 0 idle, 1 computing (m_k edges left), 2 holding result
    int         m_phase = 0;
    int         m_k     = 0;
    logic [2:0] m_res   = 3'b000;
    logic [2:0] m_pend  = 3'b000;

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("cfg%0d cycle {in_ready,out_valid,eq,gt,lt}", g),
              {27'd0, in_ready, out_valid, eq, gt, lt},
              {27'd0, (m_phase == 0), (m_phase == 2), m_res});
      end
      if (rst) begin
        m_phase = 0;
        m_res   = 3'b000;
      end else begin
        case (m_phase)
          0: if (in_valid) begin
            m_pend  = ref_bits(a, b);
            m_k     = ref_lat(a, b);
            m_phase = 1;
          end
          1: begin
            m_k--;
            if (m_k == 0) begin
              m_phase = 2;
              m_res   = m_pend;
            end
          end
          default: if (out_ready) m_phase = 0;
        endcase
      end
    end

    // Offer one pair from idle (called at posedge+1) and time its result
    task automatic run_vec(input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [2:0] exp_bits, input int exp_lat);
      int  n;
      bit  seen;
      in_valid  = 1'b1;
      a         = va;
      b         = vb;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      n        = 0;
      seen     = 1'b0;
      while (!seen && (n < 40)) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        seen = out_valid;
      end
      check($sformatf("cfg%0d vec %0h/%0h latency", g, va, vb), n, exp_lat);
      check($sformatf("cfg%0d vec %0h/%0h result", g, va, vb), {29'd0, eq, gt, lt}, {29'd0, exp_bits});
      @(posedge clk);
      #1;
    endtask

    initial begin
      logic [W-1:0] va, vb;
      logic [2:0]   exp_bits;
      vec_t         v;
      bit           seen;
      int           r;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check($sformatf("cfg%0d reset state", g), {27'd0, in_ready, out_valid, eq, gt, lt}, 32'h10);
      chk_en = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NVEC; i++) begin
        v = get_vec(i);
        if (int'(v.cfg) == g) run_vec(v.a[W-1:0], v.b[W-1:0], v.bits, int'(v.lat));
      end

      // Consumer stall: result and out_valid held, new offers ignored
      va = W'($urandom);
      vb = W'($urandom);
      exp_bits  = ref_bits(va, vb);
      in_valid  = 1'b1;
      a         = va;
      b         = vb;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      seen = 1'b0;
      for (int k = 0; (k < NDIG + 4) && !seen; k++) begin
        a = W'($urandom);
        b = W'($urandom);
        @(negedge clk);
        seen = out_valid;
        if (!seen) begin
          @(posedge clk);
          #1;
        end
      end
      check($sformatf("cfg%0d stall reaches result", g), {31'd0, seen}, 32'd1);
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        #1;
        a = W'($urandom);
        b = W'($urandom);
        @(negedge clk);
        check($sformatf("cfg%0d stall hold", g), {27'd0, in_ready, out_valid, eq, gt, lt},
              {27'd0, 2'b01, exp_bits});
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check($sformatf("cfg%0d single transfer then idle", g), {27'd0, in_ready, out_valid, eq, gt, lt},
            {27'd0, 2'b10, exp_bits});
      @(posedge clk);
      #1;

      // Reset during an operation discards it
      va       = W'($urandom);
      in_valid = 1'b1;
      a        = va;
      b        = va;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check($sformatf("cfg%0d reset mid-run", g), {27'd0, in_ready, out_valid, eq, gt, lt}, 32'h10);
      for (int k = 0; k < NDIG + 3; k++) begin
        @(negedge clk);
        check($sformatf("cfg%0d no stale result", g), {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Random traffic on both handshakes
      for (int i = 0; i < NRAND; i++) begin
        in_valid  = ($urandom_range(3) != 0);
        out_ready = ($urandom_range(3) != 0);
        a         = W'($urandom);
        r         = $urandom_range(3);
        if (r == 0)      b = a;
        else if (r == 1) b = a ^ (W'(1) << $urandom_range(W - 1));
        else             b = W'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (NDIG + 4) @(posedge clk);
      #1;
      done_cnt++;
    end
  end

  initial begin
    wait (done_cnt == NCFG);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    checks++;
    failures++;
    $display("FAIL watchdog: got %0d configs done expected %0d", done_cnt, NCFG);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
